// File: rtl/ecc_operand_io_pkg.sv
// ============================================================================
// Module : ecc_operand_io_pkg
// Brief  : Shared state encodings and default sizing for the ECC operand I/O.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ecc_operand_io_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DIGIT = 4;
  localparam int DEF_NCH   = 5;

  typedef enum logic [1:0] {
    L_IDLE = 2'd0,
    L_LOAD = 2'd1,
    L_FULL = 2'd2
  } load_state_e;

  typedef enum logic [0:0] {
    U_IDLE  = 1'b0,
    U_SHIFT = 1'b1
  } unload_state_e;

endpackage

`default_nettype wire

// File: rtl/ecc_digit_serializer.sv
// ============================================================================
// Module : ecc_digit_serializer
// Brief  : Captures a result word and emits it MSB-first, one digit per beat.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ecc_digit_serializer
  import ecc_operand_io_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             res_valid_i,
  input  logic [WIDTH-1:0] res_i,
  output logic             res_ready_o,
  output logic             out_valid_o,
  output logic [DIGIT-1:0] out_digit_o,
  output logic             out_last_o,
  input  logic             out_ready_i
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);

  unload_state_e    state_q, state_d;
  logic [WIDTH-1:0] word_q;
  logic [CW-1:0]    dcnt_q;
  logic             w_last;
  logic             w_take;
  logic             w_pop;

  assign w_last = (dcnt_q == CW'(NDIG - 1));
  assign w_take = res_valid_i && (state_q == U_IDLE);
  assign w_pop  = out_ready_i && (state_q == U_SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= U_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      U_IDLE:  if (res_valid_i) state_d = U_SHIFT;
      U_SHIFT: if (out_ready_i && w_last) state_d = U_IDLE;
      default: state_d = U_IDLE;
    endcase
  end

  // Digit and last are gated so the idle bus reads zero, not a stale word.
  always_comb begin
    res_ready_o = (state_q == U_IDLE);
    out_valid_o = (state_q == U_SHIFT);
    out_digit_o = '0;
    out_last_o  = 1'b0;
    if (state_q == U_SHIFT) begin
      out_digit_o = word_q[WIDTH-1 -: DIGIT];
      out_last_o  = w_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      dcnt_q <= '0;
    end else if (w_take) begin
      word_q <= res_i;
      dcnt_q <= '0;
    end else if (w_pop) begin
      word_q <= word_q << DIGIT;
      dcnt_q <= w_last ? '0 : dcnt_q + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ecc_operand_io.sv
// ============================================================================
// Module : ecc_operand_io
// Brief  : Digit-serial operand loader and result unloader for an ECC core.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ecc_operand_io
  import ecc_operand_io_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT,
  parameter int NCH   = DEF_NCH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [NCH*DIGIT-1:0] in_digits_i,
  input  logic                 in_clr_i,
  output logic [NCH*WIDTH-1:0] ops_o,
  output logic                 ops_valid_o,
  input  logic                 ops_ack_i,
  input  logic                 res_valid_i,
  input  logic [WIDTH-1:0]     res_i,
  output logic                 res_ready_o,
  output logic                 out_valid_o,
  output logic [DIGIT-1:0]     out_digit_o,
  output logic                 out_last_o,
  input  logic                 out_ready_i
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);

  load_state_e   lstate_q, lstate_d;
  logic [CW-1:0] count_q;
  logic          w_open;
  logic          w_clr;
  logic          w_beat;
  logic          w_final;

  // A clear in an open state wins over any beat offered in the same cycle.
  assign w_open  = (lstate_q != L_FULL);
  assign w_clr   = in_clr_i && w_open;
  assign w_beat  = in_valid_i && w_open && !in_clr_i;
  assign w_final = (lstate_q == L_IDLE) ? (NDIG == 1)
                                        : (count_q == CW'(NDIG - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lstate_q <= L_IDLE;
    else     lstate_q <= lstate_d;
  end

  always_comb begin
    lstate_d = lstate_q;
    case (lstate_q)
      L_IDLE, L_LOAD: begin
        if (w_clr)       lstate_d = L_IDLE;
        else if (w_beat) lstate_d = w_final ? L_FULL : L_LOAD;
      end
      L_FULL:  if (ops_ack_i) lstate_d = L_IDLE;
      default: lstate_d = L_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = w_open;
    ops_valid_o = (lstate_q == L_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   count_q <= '0;
    else if (w_clr)                            count_q <= '0;
    else if (w_beat && lstate_q == L_IDLE)     count_q <= CW'(1);
    else if (w_beat)                           count_q <= count_q + CW'(1);
    else if (lstate_q == L_FULL && ops_ack_i)  count_q <= '0;
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [WIDTH-1:0] ch_q;
    logic [WIDTH-1:0] w_ext;

    assign w_ext = WIDTH'(in_digits_i[c*DIGIT +: DIGIT]);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ch_q <= '0;
      end else if (w_beat) begin
        ch_q <= (lstate_q == L_IDLE) ? w_ext : ((ch_q << DIGIT) | w_ext);
      end
    end

    assign ops_o[c*WIDTH +: WIDTH] = ch_q;
  end

  ecc_digit_serializer #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) u_ser (
    .clk         (clk),
    .rst         (rst),
    .res_valid_i (res_valid_i),
    .res_i       (res_i),
    .res_ready_o (res_ready_o),
    .out_valid_o (out_valid_o),
    .out_digit_o (out_digit_o),
    .out_last_o  (out_last_o),
    .out_ready_i (out_ready_i)
  );

endmodule

`default_nettype wire
